// File: rtl/pdm_capture_pkg.sv
// Shared types and constants for the PDM capture controller.
//   state_t          : controller FSM states
//   MODE_ONESHOT/RING: values of the mode input latched at start
//   BYTES_PER_SAMPLE : bytes per sample for the default 32-bit sample width;
//                      bytes_per_sample() gives it for any width.
package pdm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int BYTES_PER_SAMPLE = DEFAULT_DATA_W / 8;

    function automatic int bytes_per_sample(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/pdm_capture_ctrl.sv
// Multi-channel capture engine between the PDM decimators and the per-channel
// BRAM write ports. PS-triggered start/stop, one-shot or ring capture, one
// shared write address for all channels, saturating wrap counter.
// Ports:
//   clk          sole clock
//   rstn         asynchronous active-low reset
//   start        trigger level, acted on at its rising edge
//   stop         stop level, acted on while high (wins over start)
//   mode         0 one-shot, 1 ring; latched at start
//   sample_valid one-cycle strobe, all channels valid together
//   sample_data  channel k at [k*DATA_W +: DATA_W]
//   bram_addr    shared byte address
//   bram_we      shared byte write enable
//   bram_din     registered copy of sample_data
//   busy / done  high in CAPTURE / DONE
//   wr_index     next sample index to be written
//   wrap_count   completed ring passes, saturating
module pdm_capture_ctrl
    import pdm_capture_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 32,
    parameter int WRAP_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [DATA_W/8-1:0]      bram_we,
    output logic [NUM_CH*DATA_W-1:0] bram_din,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] wr_index,
    output logic [WRAP_W-1:0]        wrap_count
);

    localparam int BYTES      = bytes_per_sample(DATA_W);
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                     state_reg, state_next;
    logic                       start_q_reg;
    logic                       mode_reg, mode_next;
    logic [IDX_W-1:0]           index_reg, index_next;
    logic [WRAP_W-1:0]          wrap_reg, wrap_next;
    logic [DATA_W/8-1:0]        we_reg, we_next;
    logic [NUM_CH*DATA_W-1:0]   din_reg;
    logic [ADDR_W-1:0]          addr_reg;

    logic start_rise;
    logic write_fire;

    assign start_rise = start & ~start_q_reg;
    // stop wins: a strobe in the stop cycle never reaches the BRAM
    assign write_fire = (state_reg == CAPTURE) & sample_valid & ~stop;

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        index_next = index_reg;
        wrap_next  = wrap_reg;
        we_next    = '0;
        case (state_reg)
            IDLE, DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start_rise) begin
                    state_next = CAPTURE;
                    mode_next  = mode;
                    index_next = '0;
                    wrap_next  = '0;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (sample_valid) begin
                    we_next    = '1;
                    // index wraps naturally at DEPTH (power of two)
                    index_next = index_reg + 1'b1;
                    if (index_reg == LAST_IDX) begin
                        if (mode_reg == MODE_ONESHOT) begin
                            state_next = DONE;
                        end else if (wrap_reg != '1) begin
                            wrap_next = wrap_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            start_q_reg <= 1'b0;
            mode_reg    <= MODE_ONESHOT;
            index_reg   <= '0;
            wrap_reg    <= '0;
            we_reg      <= '0;
            din_reg     <= '0;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            start_q_reg <= start;
            mode_reg    <= mode_next;
            index_reg   <= index_next;
            wrap_reg    <= wrap_next;
            we_reg      <= we_next;
            // data and address hold their last values between writes
            if (write_fire) begin
                din_reg  <= sample_data;
                addr_reg <= ADDR_W'(index_reg) << BYTE_SHIFT;
            end
        end
    end

    assign bram_addr  = addr_reg;
    assign bram_we    = we_reg;
    assign bram_din   = din_reg;
    assign busy       = (state_reg == CAPTURE);
    assign done       = (state_reg == DONE);
    assign wr_index   = index_reg;
    assign wrap_count = wrap_reg;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl. Three instances share one stimulus:
// u8 (DEPTH 8), u4 (DEPTH 4) and u2 (DEPTH 2, 2-bit wrap counter).
module tb_pdm_capture_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        sample_valid = 1'b0;
    logic [63:0] sample_data = '0;

    logic [31:0] a8, a4, a2;
    logic [3:0]  we8, we4, we2;
    logic [63:0] d8, d4, d2;
    logic        b8, b4, b2, dn8, dn4, dn2;
    logic [2:0]  i8;
    logic [1:0]  i4;
    logic [0:0]  i2;
    logic [15:0] w8, w4;
    logic [1:0]  w2;

    int tests = 0;
    int fails = 0;
    int n4, n2;

    always #5 clk = ~clk;

    pdm_capture_ctrl #(.NUM_CH(2), .DATA_W(32), .DEPTH(8), .ADDR_W(32), .WRAP_W(16)) u8 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .bram_addr(a8), .bram_we(we8), .bram_din(d8), .busy(b8), .done(dn8),
        .wr_index(i8), .wrap_count(w8));

    pdm_capture_ctrl #(.NUM_CH(2), .DATA_W(32), .DEPTH(4), .ADDR_W(32), .WRAP_W(16)) u4 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .bram_addr(a4), .bram_we(we4), .bram_din(d4), .busy(b4), .done(dn4),
        .wr_index(i4), .wrap_count(w4));

    pdm_capture_ctrl #(.NUM_CH(2), .DATA_W(32), .DEPTH(2), .ADDR_W(32), .WRAP_W(2)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .bram_addr(a2), .bram_we(we2), .bram_din(d2), .busy(b2), .done(dn2),
        .wr_index(i2), .wrap_count(w2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [31:0] c0, c1;
        c0 = 32'(i);
        c1 = 32'(32'h100 + i);
        return {c1, c0};
    endfunction

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        chk("rst_we", 64'(we8), 64'h0);
        chk("rst_addr", 64'(a8), 64'h0);
        chk("rst_din", d8, 64'h0);
        chk("rst_busy_done", {62'h0, b8, dn8}, 64'h0);
        chk("rst_index_wrap", {45'h0, i8, w8}, 64'h0);
        rstn = 1'b1;
        step();

        // ---------------- one-shot, u8 ----------------
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("os_busy", 64'(b8), 64'h1);
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            sample_data  = pat(i);
            step();
            chk($sformatf("os_we_%0d", i), 64'(we8), 64'hF);
            chk($sformatf("os_addr_%0d", i), 64'(a8), 64'(i * 4));
            chk($sformatf("os_din_%0d", i), d8, pat(i));
        end
        chk("os_done", 64'(dn8), 64'h1);
        chk("os_busy_end", 64'(b8), 64'h0);
        sample_valid = 1'b0;
        step();
        chk("os_we_idle", 64'(we8), 64'h0);
        chk("os_addr_hold", 64'(a8), 64'd28);
        sample_valid = 1'b1;
        sample_data  = pat(8);
        step();
        chk("os_9th_we", 64'(we8), 64'h0);
        chk("os_9th_din_hold", d8, pat(7));
        sample_valid = 1'b0;

        // ---------------- continuous, u4 and u2 ----------------
        mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 1'b0;  // ignored until the next start
        chk("ring_busy_start", 64'(b4), 64'h1);
        for (int i = 0; i < 12; i++) begin
            sample_valid = 1'b1;
            sample_data  = pat(i);
            step();
            if (i < 10) begin
                chk($sformatf("ring_we_%0d", i), 64'(we4), 64'hF);
                chk($sformatf("ring_addr_%0d", i), 64'(a4), 64'((i % 4) * 4));
            end
            if (i == 5) chk("sat_wrap_6", 64'(w2), 64'd3);
            if (i == 9) begin
                chk("ring_wrap", 64'(w4), 64'd2);
                chk("ring_index", 64'(i4), 64'd2);
                chk("ring_busy", 64'(b4), 64'h1);
            end
        end
        chk("sat_wrap_12", 64'(w2), 64'd3);
        chk("sat_busy", 64'(b2), 64'h1);
        chk("ring_wrap_12", 64'(w4), 64'd3);

        // ---------------- stop with a valid ----------------
        stop = 1'b1;
        sample_valid = 1'b1;
        sample_data = pat(99);
        step();
        chk("stop_we", 64'(we4), 64'h0);
        chk("stop_busy", 64'(b4), 64'h0);
        chk("stop_din_hold", d4, pat(11));
        stop = 1'b0;
        sample_valid = 1'b0;
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_wrap", 64'(w4), 64'h0);
        chk("restart_index", 64'(i4), 64'h0);
        sample_valid = 1'b1;
        sample_data = pat(3);
        step();
        chk("restart_we", 64'(we4), 64'hF);
        chk("restart_addr", 64'(a4), 64'h0);
        sample_valid = 1'b0;

        // ---------------- start and stop together ----------------
        stop = 1'b1;
        step();
        start = 1'b1;
        step();
        chk("startstop_busy", 64'(b8), 64'h0);
        chk("startstop_done", 64'(dn8), 64'h0);
        start = 1'b0;
        stop = 1'b0;
        step();
        chk("startstop_idle", 64'(b8), 64'h0);
        // start held high: exactly one capture
        start = 1'b1;
        sample_valid = 1'b1;
        n4 = 0;
        n2 = 0;
        for (int i = 0; i < 20; i++) begin
            sample_data = pat(i);
            step();
            if (we4 == 4'hF) n4++;
            if (we2 == 4'hF) n2++;
        end
        chk("held_writes_u2", 64'(n2), 64'd2);
        chk("held_writes_u4", 64'(n4), 64'd4);
        chk("held_done_u2", 64'(dn2), 64'h1);
        start = 1'b0;
        sample_valid = 1'b0;

        // ---------------- reset mid-capture ----------------
        stop = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_data = pat(i + 16);
            step();
        end
        sample_valid = 1'b0;
        chk("mid_index", 64'(i8), 64'd5);
        chk("mid_addr", 64'(a8), 64'd16);
        rstn = 1'b0;
        #1;
        chk("arst_we", 64'(we8), 64'h0);
        chk("arst_addr", 64'(a8), 64'h0);
        chk("arst_din", d8, 64'h0);
        chk("arst_busy", 64'(b8), 64'h0);
        chk("arst_index", 64'(i8), 64'h0);
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data = pat(i + 40);
            step();
            chk($sformatf("post_rst_we_%0d", i), 64'(we8), 64'h0);
        end
        chk("post_rst_index", 64'(i8), 64'h0);
        sample_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        sample_valid = 1'b1;
        sample_data = pat(50);
        step();
        chk("new_start_we", 64'(we8), 64'hF);
        chk("new_start_addr", 64'(a8), 64'h0);
        chk("new_start_din", d8, pat(50));
        sample_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
